fsm_fp_add_subt_ctrl: RTL and testbench
=======================================

// Module: fsm_fp_add_subt_ctrl
// PURPOSE
//  Control FSM of the floating-point add/subtract unit; responder side of the Begin_SUM/ACK_ADD_SUBT
//  handshake driven by the CORDIC/LN sequencers. It accepts one operation per request and steps the
//  FP datapath through load, exponent compare, align, add, normalize, round and pack, then acks.
//  It issues register enables and mux selects only; the datapath returns status flags.
// PARAMETERS
//  SW        23  significand fraction width (single precision)
//  MAX_NORM  25  max normalization left shifts (SW+2) before the result is forced to zero
// PORTS
//  CLK            in   1  system clock, all state on rising edge
//  RST_N          in   1  asynchronous active-low reset
//  Begin_FSM      in   1  start request (1-cycle pulse from initiator's Begin_SUM)
//  ADD_SUBT       in   1  0=add, 1=subtract; captured on accepted Begin_FSM
//  SGF_ZERO       in   1  aligned-sum significand is zero
//  SGF_CARRY      in   1  sum overflowed into bit SW+1 (needs one right shift)
//  SGF_MSB        in   1  hidden-bit position of sum is 1 (normalized)
//  ROUND_CARRY    in   1  rounding increment overflowed significand
//  EXP_MAX        in   1  updated exponent is all ones (overflow)
//  EXP_MIN        in   1  updated exponent is zero (underflow)
//  EN_OPS         out  1  load X/Y operand registers
//  EN_EXP_DIFF    out  1  load exponent-difference/swap register
//  EN_SHIFT       out  1  load aligned smaller-operand significand
//  EN_SGF_ADD     out  1  load add/sub result register
//  OP_REG         out  1  registered ADD_SUBT for the datapath adder
//  EN_NORM        out  1  shift normalization register one bit
//  SHIFT_DIR      out  1  0=left, 1=right (valid with EN_NORM)
//  EN_EXP_UPD     out  1  update result exponent
//  EXP_INC        out  1  1=exp+1, 0=exp-1 (valid with EN_EXP_UPD)
//  EN_ROUND       out  1  load rounded significand
//  LOAD_ZERO      out  1  force packed result to +0
//  EN_OUT         out  1  load final result register
//  OVERFLOW_FLAG  out  1  registered; set in PACK on EXP_MAX, cleared on next accepted Begin_FSM
//  UNDERFLOW_FLAG out  1  registered; set in PACK on EXP_MIN (nonzero result), cleared likewise
//  ACK_FSM        out  1  1-cycle done pulse to initiator (ACK_ADD_SUBT)
//  BUSY           out  1  high in every state except IDLE
// BEHAVIOUR
//  - Reset (RST_N=0, any time incl. mid-op): state=IDLE, norm counter=0, OP_REG=0, both flags=0;
//    all other outputs combinational from state, hence 0 in IDLE. No ack is issued for an aborted op.
//  - Outputs not named for a state are 0 in that state.
//  - IDLE: Begin_FSM=1 -> LOAD; capture OP_REG<=ADD_SUBT, clear flags and counter. Else stay.
//  - LOAD: EN_OPS -> EXP_CMP.   EXP_CMP: EN_EXP_DIFF -> ALIGN.   ALIGN: EN_SHIFT -> ADD.
//  - ADD: EN_SGF_ADD -> NORM.
//  - NORM, priority order:
//      SGF_ZERO -> PACK with LOAD_ZERO held through PACK (ROUND skipped, no underflow flag);
//      SGF_CARRY -> EN_NORM, SHIFT_DIR=1, EN_EXP_UPD, EXP_INC=1, stay NORM;
//      SGF_MSB or EXP_MIN -> ROUND;
//      else EN_NORM, SHIFT_DIR=0, EN_EXP_UPD, EXP_INC=0, counter+1, stay NORM;
//      counter==MAX_NORM -> PACK with LOAD_ZERO (safety bound).
//  - ROUND: EN_ROUND; ROUND_CARRY=1 -> FIXUP else PACK.
//  - FIXUP: EN_NORM, SHIFT_DIR=1, EN_EXP_UPD, EXP_INC=1 -> PACK (taken at most once).
//  - PACK: EN_OUT; OVERFLOW_FLAG<=EXP_MAX; UNDERFLOW_FLAG<=EXP_MIN & ~LOAD_ZERO path -> ACK.
//  - ACK: ACK_FSM=1 for exactly one cycle -> IDLE. Begin_FSM seen in ACK or any busy state is dropped.
//  - Latency: Begin_FSM sampled at edge 0, ACK_FSM high in cycle 8 when NORM exits immediately;
//    +1 cycle per normalization shift, +1 if FIXUP taken. Zero result: ACK in cycle 7.
//  - Back-to-back: a new Begin_FSM is accepted in the cycle after ACK (IDLE). ACK never stays high,
//    so an initiator polling ACK after its next Begin cannot see a stale ack.
//  - Counter width $clog2(MAX_NORM+1); it never wraps (bounded by the MAX_NORM exit).
// STRUCTURE
//  - fp_add_subt_defs.vh: state encodings (IDLE..ACK, 4-bit), SHIFT_L/SHIFT_R, EXP_DEC/EXP_INC.
//  - Sub-module norm_shift_counter: clear/increment/terminal-count (==MAX_NORM) with async reset.
//  - Next-state/output logic: one combinational block with defaults first; state, counter,
//    OP_REG and flags are the only flops.
// TESTING
//  1. 1.0+1.0 (SGF_CARRY=1 once, then SGF_MSB=1) -> one right shift with EXP_INC=1, ACK in cycle 9.
//  2. 1.5-1.0 (SGF_MSB=0 for 1 cycle) -> one left shift with EXP_INC=0, OP_REG=1, ACK in cycle 9.
//  3. 2.0-2.0 (SGF_ZERO=1) -> LOAD_ZERO in NORM and PACK, no EN_ROUND, flags 0, ACK in cycle 7.
//  4. ROUND_CARRY=1 -> FIXUP right shift, then PACK; with EXP_MAX=1 in PACK -> OVERFLOW_FLAG=1
//     after ACK, cleared by the next Begin_FSM.
//  5. Begin_FSM pulses in cycles 3 and 8 -> both ignored, single ACK; Begin in cycle 10 -> accepted.
//  6. RST_N low in cycle 5 mid-NORM -> all outputs 0 immediately, IDLE, no ACK_FSM; new op completes.

Source files
------------

// File: rtl/fsm_fp_add_subt_ctrl_pkg.sv
// Shared types and constants for the FP add/subtract control FSM.
// Holds the state encoding, the shift/exponent direction codes, the bundle
// of datapath control strobes and helpers that build common strobe patterns.
package fsm_fp_add_subt_ctrl_pkg;

  // Sequencer states. PACK_ZERO is the PACK step of the forced-zero path; it
  // is a separate state so LOAD_ZERO can be held without an extra flop.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD      = 4'd1,
    ST_EXP_CMP   = 4'd2,
    ST_ALIGN     = 4'd3,
    ST_ADD       = 4'd4,
    ST_NORM      = 4'd5,
    ST_ROUND     = 4'd6,
    ST_FIXUP     = 4'd7,
    ST_PACK      = 4'd8,
    ST_PACK_ZERO = 4'd9,
    ST_ACK       = 4'd10
  } state_e;

  // Normalization shift direction (SHIFT_DIR).
  localparam logic SHIFT_L = 1'b0;
  localparam logic SHIFT_R = 1'b1;

  // Exponent update direction (EXP_INC).
  localparam logic EXP_STEP_DEC = 1'b0;
  localparam logic EXP_STEP_INC = 1'b1;

  // Every per-state control strobe driven to the datapath.
  typedef struct packed {
    logic en_ops;
    logic en_exp_diff;
    logic en_shift;
    logic en_sgf_add;
    logic en_norm;
    logic shift_dir;
    logic en_exp_upd;
    logic exp_inc;
    logic en_round;
    logic load_zero;
    logic en_out;
    logic ack;
  } ctrl_t;

  // Width of a counter that must hold 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // One-bit normalization step: a right shift always pairs with exp+1,
  // a left shift with exp-1.
  function automatic ctrl_t norm_step(input logic dir);
    ctrl_t c;
    c            = '0;
    c.en_norm    = 1'b1;
    c.shift_dir  = dir;
    c.en_exp_upd = 1'b1;
    c.exp_inc    = (dir == SHIFT_R) ? EXP_STEP_INC : EXP_STEP_DEC;
    return c;
  endfunction

endpackage

// File: rtl/fsm_fp_add_subt_ctrl_norm_shift_counter.sv
// Normalization left-shift counter.
// Cleared when a new operation is accepted, incremented once per left shift,
// and saturating at MAX_NORM; tc_o flags that the shift budget is spent.
module fsm_fp_add_subt_ctrl_norm_shift_counter #(
  parameter int MAX_NORM = 25,
  localparam int CW      = fsm_fp_add_subt_ctrl_pkg::cnt_width(MAX_NORM)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          tc_s;

  assign tc_s = (count_q == CW'(MAX_NORM));
  assign tc_o = tc_s;

  // Next count: clear wins, increment stops at the terminal count.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !tc_s) begin
      count_d = count_q + CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fsm_fp_add_subt_ctrl.sv
// Control FSM of the floating-point add/subtract unit.
// Responds to a Begin_FSM pulse, walks the datapath through load, exponent
// compare, align, add, normalize, round and pack, then pulses ACK_FSM once.
// Only state, the normalization counter, OP_REG and the two flags are flops;
// all strobes are decoded combinationally from the current state.
module fsm_fp_add_subt_ctrl
  import fsm_fp_add_subt_ctrl_pkg::*;
#(
  parameter int SW       = 23,
  parameter int MAX_NORM = SW + 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic Begin_FSM,
  input  logic ADD_SUBT,
  input  logic SGF_ZERO,
  input  logic SGF_CARRY,
  input  logic SGF_MSB,
  input  logic ROUND_CARRY,
  input  logic EXP_MAX,
  input  logic EXP_MIN,
  output logic EN_OPS,
  output logic EN_EXP_DIFF,
  output logic EN_SHIFT,
  output logic EN_SGF_ADD,
  output logic OP_REG,
  output logic EN_NORM,
  output logic SHIFT_DIR,
  output logic EN_EXP_UPD,
  output logic EXP_INC,
  output logic EN_ROUND,
  output logic LOAD_ZERO,
  output logic EN_OUT,
  output logic OVERFLOW_FLAG,
  output logic UNDERFLOW_FLAG,
  output logic ACK_FSM,
  output logic BUSY
);

  state_e state_q;
  state_e state_d;
  logic   op_reg_q;
  logic   op_reg_d;
  logic   ovf_q;
  logic   ovf_d;
  logic   unf_q;
  logic   unf_d;
  ctrl_t  ctrl_s;
  logic   cnt_clr_s;
  logic   cnt_inc_s;
  logic   cnt_tc_s;

  fsm_fp_add_subt_ctrl_norm_shift_counter #(
    .MAX_NORM (MAX_NORM)
  ) u_norm_cnt (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .clr_i   (cnt_clr_s),
    .inc_i   (cnt_inc_s),
    .tc_o    (cnt_tc_s)
  );

  // Next-state, control strobes and flag/opcode updates for the sequencer.
  always_comb begin
    state_d   = state_q;
    op_reg_d  = op_reg_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    ctrl_s    = '0;
    case (state_q)
      ST_IDLE: begin
        if (Begin_FSM) begin
          state_d   = ST_LOAD;
          op_reg_d  = ADD_SUBT;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
          cnt_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        ctrl_s.en_ops = 1'b1;
        state_d       = ST_EXP_CMP;
      end
      ST_EXP_CMP: begin
        ctrl_s.en_exp_diff = 1'b1;
        state_d            = ST_ALIGN;
      end
      ST_ALIGN: begin
        ctrl_s.en_shift = 1'b1;
        state_d         = ST_ADD;
      end
      ST_ADD: begin
        ctrl_s.en_sgf_add = 1'b1;
        state_d           = ST_NORM;
      end
      ST_NORM: begin
        if (SGF_ZERO) begin
          // Exact cancellation: skip rounding and pack +0.
          ctrl_s.load_zero = 1'b1;
          state_d          = ST_PACK_ZERO;
        end else if (SGF_CARRY) begin
          ctrl_s  = norm_step(SHIFT_R);
          state_d = ST_NORM;
        end else if (SGF_MSB || EXP_MIN) begin
          // Normalized, or no exponent range left to shift into.
          state_d = ST_ROUND;
        end else if (cnt_tc_s) begin
          // Shift budget exhausted: the significand can only be zero.
          ctrl_s.load_zero = 1'b1;
          state_d          = ST_PACK_ZERO;
        end else begin
          ctrl_s    = norm_step(SHIFT_L);
          cnt_inc_s = 1'b1;
          state_d   = ST_NORM;
        end
      end
      ST_ROUND: begin
        ctrl_s.en_round = 1'b1;
        if (ROUND_CARRY) begin
          state_d = ST_FIXUP;
        end else begin
          state_d = ST_PACK;
        end
      end
      ST_FIXUP: begin
        // Rounding overflow needs exactly one right shift; the result is
        // then a power of two, so rounding cannot carry again.
        ctrl_s  = norm_step(SHIFT_R);
        state_d = ST_PACK;
      end
      ST_PACK: begin
        ctrl_s.en_out = 1'b1;
        ovf_d         = EXP_MAX;
        unf_d         = EXP_MIN;
        state_d       = ST_ACK;
      end
      ST_PACK_ZERO: begin
        // A forced zero is not an underflow.
        ctrl_s.en_out    = 1'b1;
        ctrl_s.load_zero = 1'b1;
        ovf_d            = EXP_MAX;
        unf_d            = 1'b0;
        state_d          = ST_ACK;
      end
      ST_ACK: begin
        ctrl_s.ack = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, opcode and sticky-until-next-op flag registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      op_reg_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_reg_q <= op_reg_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign EN_OPS         = ctrl_s.en_ops;
  assign EN_EXP_DIFF    = ctrl_s.en_exp_diff;
  assign EN_SHIFT       = ctrl_s.en_shift;
  assign EN_SGF_ADD     = ctrl_s.en_sgf_add;
  assign EN_NORM        = ctrl_s.en_norm;
  assign SHIFT_DIR      = ctrl_s.shift_dir;
  assign EN_EXP_UPD     = ctrl_s.en_exp_upd;
  assign EXP_INC        = ctrl_s.exp_inc;
  assign EN_ROUND       = ctrl_s.en_round;
  assign LOAD_ZERO      = ctrl_s.load_zero;
  assign EN_OUT         = ctrl_s.en_out;
  assign ACK_FSM        = ctrl_s.ack;
  assign OP_REG         = op_reg_q;
  assign OVERFLOW_FLAG  = ovf_q;
  assign UNDERFLOW_FLAG = unf_q;
  assign BUSY           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fsm_fp_add_subt_ctrl.sv
// Testbench for fsm_fp_add_subt_ctrl: table of operations expanded into
// per-cycle stimulus with expected outputs, checked through a scoreboard
// queue, plus a hand-written mid-operation reset sequence.
module tb_fsm_fp_add_subt_ctrl;

  localparam int MAX_NORM = 25;

  // Output word bit positions (matches the obs concatenation below).
  localparam logic [15:0] O_OPS   = 16'h8000;
  localparam logic [15:0] O_DIFF  = 16'h4000;
  localparam logic [15:0] O_SHIFT = 16'h2000;
  localparam logic [15:0] O_ADD   = 16'h1000;
  localparam logic [15:0] O_OPREG = 16'h0800;
  localparam logic [15:0] O_NORM  = 16'h0400;
  localparam logic [15:0] O_DIR   = 16'h0200;
  localparam logic [15:0] O_UPD   = 16'h0100;
  localparam logic [15:0] O_INC   = 16'h0080;
  localparam logic [15:0] O_ROUND = 16'h0040;
  localparam logic [15:0] O_ZERO  = 16'h0020;
  localparam logic [15:0] O_OUT   = 16'h0010;
  localparam logic [15:0] O_OVF   = 16'h0008;
  localparam logic [15:0] O_UNF   = 16'h0004;
  localparam logic [15:0] O_ACK   = 16'h0002;
  localparam logic [15:0] O_BUSY  = 16'h0001;

  logic CLK = 1'b0;
  logic RST_N;
  logic Begin_FSM, ADD_SUBT, SGF_ZERO, SGF_CARRY, SGF_MSB, ROUND_CARRY, EXP_MAX, EXP_MIN;
  logic EN_OPS, EN_EXP_DIFF, EN_SHIFT, EN_SGF_ADD, OP_REG, EN_NORM, SHIFT_DIR, EN_EXP_UPD;
  logic EXP_INC, EN_ROUND, LOAD_ZERO, EN_OUT, OVERFLOW_FLAG, UNDERFLOW_FLAG, ACK_FSM, BUSY;
  logic [15:0] obs;

  fsm_fp_add_subt_ctrl #(.SW(23), .MAX_NORM(MAX_NORM)) dut (
    .CLK(CLK), .RST_N(RST_N), .Begin_FSM(Begin_FSM), .ADD_SUBT(ADD_SUBT),
    .SGF_ZERO(SGF_ZERO), .SGF_CARRY(SGF_CARRY), .SGF_MSB(SGF_MSB),
    .ROUND_CARRY(ROUND_CARRY), .EXP_MAX(EXP_MAX), .EXP_MIN(EXP_MIN),
    .EN_OPS(EN_OPS), .EN_EXP_DIFF(EN_EXP_DIFF), .EN_SHIFT(EN_SHIFT),
    .EN_SGF_ADD(EN_SGF_ADD), .OP_REG(OP_REG), .EN_NORM(EN_NORM),
    .SHIFT_DIR(SHIFT_DIR), .EN_EXP_UPD(EN_EXP_UPD), .EXP_INC(EXP_INC),
    .EN_ROUND(EN_ROUND), .LOAD_ZERO(LOAD_ZERO), .EN_OUT(EN_OUT),
    .OVERFLOW_FLAG(OVERFLOW_FLAG), .UNDERFLOW_FLAG(UNDERFLOW_FLAG),
    .ACK_FSM(ACK_FSM), .BUSY(BUSY)
  );

  assign obs = {EN_OPS, EN_EXP_DIFF, EN_SHIFT, EN_SGF_ADD, OP_REG, EN_NORM, SHIFT_DIR,
                EN_EXP_UPD, EXP_INC, EN_ROUND, LOAD_ZERO, EN_OUT, OVERFLOW_FLAG,
                UNDERFLOW_FLAG, ACK_FSM, BUSY};

  always #5 CLK = ~CLK;

  typedef struct {
    logic op, zero, min_exit, rc, emax, emin, noise;
    int   nc, nl, ack_cyc;
  } vec_t;

  typedef struct {
    logic beg, op, zero, carry, msb, rcarry, emax, emin;
    logic [15:0] exp;
  } step_t;

  vec_t        tbl[10];
  step_t       plan_q[$];
  logic [15:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        m_op  = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  function automatic vec_t mkvec(input logic op, zero, input int nc, nl, input logic min_exit,
                                 rc, emax, emin, noise, input int ack_cyc);
    vec_t v;
    v.op = op; v.zero = zero; v.nc = nc; v.nl = nl; v.min_exit = min_exit; v.rc = rc;
    v.emax = emax; v.emin = emin; v.noise = noise; v.ack_cyc = ack_cyc;
    return v;
  endfunction

  // Expected OP_REG / flag / BUSY bits from the model state.
  function automatic logic [15:0] stat(input logic busy);
    return (busy ? O_BUSY : 16'h0000) | (m_op ? O_OPREG : 16'h0000) |
           (m_ovf ? O_OVF : 16'h0000) | (m_unf ? O_UNF : 16'h0000);
  endfunction

  function automatic step_t blank(input logic [15:0] e);
    step_t s;
    s.beg = 1'b0; s.op = ~m_op; s.zero = 1'b0; s.carry = 1'b0; s.msb = 1'b0;
    s.rcarry = 1'b0; s.emax = 1'b0; s.emin = 1'b0; s.exp = e;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expand one operation into a cycle-by-cycle plan (cycle 0 = Begin cycle).
  task automatic build(input vec_t v);
    step_t s;
    int    cnt;
    int    rem;
    s = blank(stat(1'b0)); s.beg = 1'b1; s.op = v.op; plan_q.push_back(s);
    m_op = v.op; m_ovf = 1'b0; m_unf = 1'b0;
    plan_q.push_back(blank(O_OPS  | stat(1'b1)));
    s = blank(O_DIFF | stat(1'b1)); plan_q.push_back(s);
    s = blank(O_SHIFT | stat(1'b1)); s.beg = v.noise; plan_q.push_back(s);
    plan_q.push_back(blank(O_ADD  | stat(1'b1)));
    if (v.zero) begin
      s = blank(O_ZERO | stat(1'b1)); s.zero = 1'b1; plan_q.push_back(s);
      s = blank(O_OUT | O_ZERO | stat(1'b1)); s.emax = v.emax; s.emin = v.emin;
      plan_q.push_back(s);
      m_ovf = v.emax; m_unf = 1'b0;
    end else begin
      for (int i = 0; i < v.nc; i++) begin
        s = blank(O_NORM | O_DIR | O_UPD | O_INC | stat(1'b1)); s.carry = 1'b1;
        plan_q.push_back(s);
      end
      cnt = 0; rem = v.nl;
      while (rem > 0 && cnt < MAX_NORM) begin
        plan_q.push_back(blank(O_NORM | O_UPD | stat(1'b1)));
        cnt++; rem--;
      end
      if (rem > 0) begin
        plan_q.push_back(blank(O_ZERO | stat(1'b1)));
        s = blank(O_OUT | O_ZERO | stat(1'b1)); s.emax = v.emax; s.emin = v.emin;
        plan_q.push_back(s);
        m_ovf = v.emax; m_unf = 1'b0;
      end else begin
        s = blank(stat(1'b1)); s.msb = ~v.min_exit; s.emin = v.min_exit; plan_q.push_back(s);
        s = blank(O_ROUND | stat(1'b1)); s.rcarry = v.rc; plan_q.push_back(s);
        if (v.rc) plan_q.push_back(blank(O_NORM | O_DIR | O_UPD | O_INC | stat(1'b1)));
        s = blank(O_OUT | stat(1'b1)); s.emax = v.emax; s.emin = v.emin; plan_q.push_back(s);
        m_ovf = v.emax; m_unf = v.emin;
      end
    end
    s = blank(O_ACK | stat(1'b1)); s.beg = v.noise; plan_q.push_back(s);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    step_t       s;
    logic [15:0] e;
    int          k;
    int          ack_at;
    build(v);
    k = 0; ack_at = -1;
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      @(posedge CLK); #1;
      Begin_FSM = s.beg; ADD_SUBT = s.op; SGF_ZERO = s.zero; SGF_CARRY = s.carry;
      SGF_MSB = s.msb; ROUND_CARRY = s.rcarry; EXP_MAX = s.emax; EXP_MIN = s.emin;
      sb_q.push_back(s.exp);
      @(negedge CLK);
      e = sb_q.pop_front();
      check($sformatf("vec%0d_cycle%0d", id, k), {16'h0000, obs}, {16'h0000, e});
      if (ACK_FSM === 1'b1 && ack_at < 0) ack_at = k;
      k++;
    end
    check($sformatf("vec%0d_ack_cycle", id), ack_at, v.ack_cyc);
  endtask

  task automatic drive_idle();
    Begin_FSM = 1'b0; ADD_SUBT = 1'b0; SGF_ZERO = 1'b0; SGF_CARRY = 1'b0;
    SGF_MSB = 1'b0; ROUND_CARRY = 1'b0; EXP_MAX = 1'b0; EXP_MIN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    RST_N = 1'b0;
    drive_idle();
    //                  op   zero nc nl min  rc   emax emin noise ack
    tbl[0] = mkvec(1'b0, 1'b0, 1, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9);   // 1.0+1.0
    tbl[1] = mkvec(1'b1, 1'b0, 0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9);   // 1.5-1.0
    tbl[2] = mkvec(1'b1, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);   // 2.0-2.0
    tbl[3] = mkvec(1'b0, 1'b0, 0, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9);   // round carry + overflow
    tbl[4] = mkvec(1'b0, 1'b0, 0, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);   // stray Begin in 3 and 8
    tbl[5] = mkvec(1'b1, 1'b0, 0, 2,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10);  // underflow
    tbl[6] = mkvec(1'b0, 1'b0, 0, 1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9);   // EXP_MIN stops normalize
    tbl[7] = mkvec(1'b0, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7);   // zero: no underflow flag
    tbl[8] = mkvec(1'b1, 1'b0, 0, 99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32);  // shift budget exhausted
    tbl[9] = mkvec(1'b1, 1'b0, 0, 3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12);  // shifts + fixup

    #2;
    check("reset_outputs_async", {16'h0000, obs}, 32'h0000_0000);
    @(negedge CLK);
    check("reset_outputs", {16'h0000, obs}, 32'h0000_0000);
    RST_N = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // Mid-operation reset: start a subtract, reset while in NORM (cycle 5).
    @(posedge CLK); #1;
    drive_idle(); Begin_FSM = 1'b1; ADD_SUBT = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge CLK); #1;
      drive_idle();
    end
    #2;
    RST_N = 1'b0;
    #1;
    check("midop_reset_outputs", {16'h0000, obs}, 32'h0000_0000);
    @(posedge CLK); #1;
    check("midop_reset_held", {16'h0000, obs}, 32'h0000_0000);
    @(negedge CLK);
    RST_N = 1'b1;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (ACK_FSM === 1'b1) acks++;
    end
    check("no_ack_after_abort", acks, 0);
    m_op = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    run_vec(100, tbl[1]);

    @(posedge CLK); #1;
    drive_idle();
    @(negedge CLK);
    check("final_idle", {16'h0000, obs}, {16'h0000, stat(1'b0)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
